// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: EX/MEM field offsets, access FSM states
// and branch condition codes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } accState_e;

  localparam logic [3:0] BR_ALWAYS = 4'd0;
  localparam logic [3:0] BR_EQ     = 4'd1;
  localparam logic [3:0] BR_NE     = 4'd2;
  localparam logic [3:0] BR_LT     = 4'd3;
  localparam logic [3:0] BR_GT     = 4'd4;

  // Bit positions inside the EX/MEM word, as functions of the datapath width.
  function automatic int rcLsb(input int n);       return n;          endfunction
  function automatic int regWriteBit(input int n); return n + 4;      endfunction
  function automatic int memToRegBit(input int n); return n + 5;      endfunction
  function automatic int memWriteBit(input int n); return n + 6;      endfunction
  function automatic int branchBit(input int n);   return n + 7;      endfunction
  function automatic int negBit(input int n);      return n + 8;      endfunction
  function automatic int zeroBit(input int n);     return n + 9;      endfunction
  function automatic int aluLsb(input int n);      return n + 10;     endfunction
  function automatic int opCodeLsb(input int n);   return 2 * n + 10; endfunction
  function automatic int opTypeLsb(input int n);   return 2 * n + 14; endfunction
  function automatic int exWidth(input int n);     return 2 * n + 16; endfunction
  function automatic int wbWidth(input int n);     return 2 * n + 6;  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake controller: sequences IDLE/REQ/DONE, keeps the timeout
// counter and the hold register, and produces stall and memReq.
module mem_access_fsm
  import mem_pkg::*;
#(
  parameter int N       = 24,
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         memOp_i,
  input  logic         memAck_i,
  input  logic [N-1:0] memRData_i,
  output logic         stall_o,
  output logic         memReq_o,
  output logic         memErr_o,
  output logic         abort_o,
  output logic         memCycle_o,
  output logic [N-1:0] loadData_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  accState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     hold_q, hold_d;
  logic             err_q, err_d;
  logic             stall, req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    stall   = 1'b0;
    req     = 1'b0;
    abort_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memOp_i) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (memAck_i) begin
          if (en_i) begin
            state_d = IDLE;
          end else begin
            stall   = 1'b1;
            hold_d  = memRData_i;
            state_d = DONE;
          end
        end else begin
          stall = 1'b1;
          // The last permitted cycle without an ack gives up on the access.
          if (cnt_q == CNT_LAST) begin
            abort_o = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (en_i) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so both fall the moment reset rises, not at the next edge.
  assign stall_o    = stall & ~rst_i;
  assign memReq_o   = req & ~rst_i;
  assign memErr_o   = err_q;
  assign memCycle_o = (state_q != IDLE);
  assign loadData_o = (state_q == REQ) ? memRData_i : hold_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory access via mem_access_fsm,
// and the registered MEM/WB word.
module mem_stage
  import mem_pkg::*;
#(
  parameter int N       = 24,
  parameter int EX_BW   = 16 + 2 * N,
  parameter int WB_BW   = 2 * N + 6,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [EX_BW-1:0] exMemIn_i,
  input  logic [N-1:0]     memRData_i,
  input  logic             memAck_i,
  output logic             memReq_o,
  output logic             memWe_o,
  output logic [N-1:0]     memAddr_o,
  output logic [N-1:0]     memWData_o,
  output logic             stall_o,
  output logic             pcSrc_o,
  output logic [N-1:0]     branchTgt_o,
  output logic             memErr_o,
  output logic [WB_BW-1:0] memWbOut_o
);

  logic [3:0]   opCode;
  logic [N-1:0] alu, rd3, loadData, readData;
  logic [3:0]   rc;
  logic         zero, neg, branch, memWrite, memToReg, regWrite, memOp;
  logic         stall, abort, memCycle, taken;
  logic         unusedOpType;

  logic [WB_BW-1:0] memWb_q, memWb_d;

  assign opCode       = exMemIn_i[opCodeLsb(N) +: 4];
  assign alu          = exMemIn_i[aluLsb(N) +: N];
  assign zero         = exMemIn_i[zeroBit(N)];
  assign neg          = exMemIn_i[negBit(N)];
  assign branch       = exMemIn_i[branchBit(N)];
  assign memWrite     = exMemIn_i[memWriteBit(N)];
  assign memToReg     = exMemIn_i[memToRegBit(N)];
  assign regWrite     = exMemIn_i[regWriteBit(N)];
  assign rc           = exMemIn_i[rcLsb(N) +: 4];
  assign rd3          = exMemIn_i[N-1:0];
  assign unusedOpType = ^exMemIn_i[opTypeLsb(N) +: 2];
  assign memOp        = memWrite | memToReg;

  mem_access_fsm #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .memOp_i    (memOp),
    .memAck_i   (memAck_i),
    .memRData_i (memRData_i),
    .stall_o    (stall),
    .memReq_o   (memReq_o),
    .memErr_o   (memErr_o),
    .abort_o    (abort),
    .memCycle_o (memCycle),
    .loadData_o (loadData)
  );

  assign stall_o     = stall;
  assign memWe_o     = memReq_o & memWrite;
  assign memAddr_o   = alu;
  assign memWData_o  = rd3;
  assign branchTgt_o = alu;

  always_comb begin
    taken = 1'b0;
    case (opCode)
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = zero;
      BR_NE:     taken = ~zero;
      BR_LT:     taken = neg;
      BR_GT:     taken = ~neg & ~zero;
      default:   taken = 1'b0;
    endcase
  end

  assign pcSrc_o = branch & taken & ~stall;

  // Any cycle that does not retire while en is high writes a bubble so the
  // held instruction is never written back twice.
  always_comb begin
    readData = (memCycle & memToReg) ? loadData : '0;
    memWb_d  = memWb_q;
    if (flush_i || abort) begin
      memWb_d = '0;
    end else if (en_i) begin
      if (stall) begin
        memWb_d = '0;
      end else begin
        memWb_d = {regWrite, memToReg, rc, readData, alu};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memWb_q <= '0;
    end else begin
      memWb_q <= memWb_d;
    end
  end

  assign memWbOut_o = memWb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against a transaction-level expectation model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [63:0] exMemIn;
  logic [23:0] memRData;
  logic        memAck;
  logic        memReq;
  logic        memWe;
  logic [23:0] memAddr;
  logic [23:0] memWData;
  logic        stall;
  logic        pcSrc;
  logic [23:0] branchTgt;
  logic        memErr;
  logic [53:0] memWbOut;

  int checks = 0;
  int errors = 0;
  logic [53:0] expWb;

  mem_stage dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .flush_i     (flush),
    .exMemIn_i   (exMemIn),
    .memRData_i  (memRData),
    .memAck_i    (memAck),
    .memReq_o    (memReq),
    .memWe_o     (memWe),
    .memAddr_o   (memAddr),
    .memWData_o  (memWData),
    .stall_o     (stall),
    .pcSrc_o     (pcSrc),
    .branchTgt_o (branchTgt),
    .memErr_o    (memErr),
    .memWbOut_o  (memWbOut)
  );

  always #5 clk = ~clk;

  // EX/MEM word: {opType, opCode, alu, zero, neg, branch, memWrite, memToReg, regWrite, Rc, rd3}
  function automatic logic [63:0] buildEx(input logic [3:0] op, input logic [23:0] alu,
                                          input logic z, input logic n, input logic br,
                                          input logic mw, input logic mtr, input logic rw,
                                          input logic [3:0] rc, input logic [23:0] rd3);
    return {2'b00, op, alu, z, n, br, mw, mtr, rw, rc, rd3};
  endfunction

  function automatic logic [53:0] wbWord(input logic rw, input logic mtr, input logic [3:0] rc,
                                         input logic [23:0] rdata, input logic [23:0] alu);
    return {rw, mtr, rc, rdata, alu};
  endfunction

  // Branch conditions read as comparisons of the ALU result against zero.
  function automatic logic brModel(input logic [3:0] op, input logic z, input logic n);
    logic pos;
    pos = !n && !z;
    return (op == 4'd0) || (op == 4'd1 && z) || (op == 4'd2 && !z) ||
           (op == 4'd3 && n) || (op == 4'd4 && pos);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] ex, input logic e, input logic f,
                               input logic ack, input logic [23:0] rd);
    exMemIn  = ex;
    en       = e;
    flush    = f;
    memAck   = ack;
    memRData = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runAlu(input logic [3:0] op, input logic [23:0] alu, input logic z,
                        input logic n, input logic br, input logic rw, input logic [3:0] rc,
                        input logic [23:0] rd3, input logic e, input logic f);
    logic [63:0] ex;
    ex = buildEx(op, alu, z, n, br, 1'b0, 1'b0, rw, rc, rd3);
    applyStimulus(ex, e, f, 1'($urandom % 2), 24'($urandom));
    checkOutput("aluStall", stall, 0);
    checkOutput("aluReq", memReq, 0);
    checkOutput("aluPcSrc", pcSrc, br & brModel(op, z, n));
    checkOutput("aluTgt", branchTgt, alu);
    tick();
    if (f) expWb = '0;
    else if (e) expWb = wbWord(rw, 1'b0, rc, 24'h0, alu);
    checkOutput("aluWb", memWbOut, expWb);
  endtask

  task automatic runMemOp(input logic isStore, input logic [23:0] addr, input logic [23:0] wdata,
                          input logic [3:0] rc, input logic rw, input logic [3:0] op,
                          input logic br, input logic [23:0] ackData, input int waits,
                          input int holdExtra, input logic useHold, input logic flushWait);
    logic [63:0] ex;
    logic z, n, taken;
    logic [53:0] word;
    z     = 1'($urandom % 2);
    n     = 1'($urandom % 2);
    taken = br & brModel(op, z, n);
    ex    = buildEx(op, addr, z, n, br, isStore, !isStore, rw, rc, wdata);
    word  = wbWord(rw, !isStore, rc, isStore ? 24'h0 : ackData, addr);

    applyStimulus(ex, 1'b1, 1'b0, 1'($urandom % 2), 24'($urandom));
    checkOutput("idleStall", stall, 1);
    checkOutput("idleReq", memReq, 0);
    checkOutput("idlePcSrc", pcSrc, 0);
    tick();
    expWb = '0;
    checkOutput("idleBubble", memWbOut, expWb);

    for (int i = 0; i < waits; i++) begin
      applyStimulus(ex, 1'b1, flushWait, 1'b0, 24'($urandom));
      checkOutput("waitReq", memReq, 1);
      checkOutput("waitWe", memWe, isStore);
      checkOutput("waitAddr", memAddr, addr);
      checkOutput("waitWData", memWData, wdata);
      checkOutput("waitStall", stall, 1);
      checkOutput("waitPcSrc", pcSrc, 0);
      tick();
      checkOutput("waitBubble", memWbOut, expWb);
    end

    applyStimulus(ex, !useHold, 1'b0, 1'b1, ackData);
    checkOutput("ackReq", memReq, 1);
    checkOutput("ackWe", memWe, isStore);
    checkOutput("ackStall", stall, useHold);
    checkOutput("ackPcSrc", pcSrc, useHold ? 1'b0 : taken);
    tick();
    if (!useHold) expWb = word;
    checkOutput("ackWb", memWbOut, expWb);

    if (useHold) begin
      for (int j = 0; j < holdExtra; j++) begin
        applyStimulus(ex, 1'b0, 1'b0, 1'($urandom % 2), 24'($urandom));
        checkOutput("doneReq", memReq, 0);
        checkOutput("doneStall", stall, 1);
        tick();
        checkOutput("doneHoldWb", memWbOut, expWb);
      end
      applyStimulus(ex, 1'b1, 1'b0, 1'($urandom % 2), 24'($urandom));
      checkOutput("releaseReq", memReq, 0);
      checkOutput("releaseStall", stall, 0);
      checkOutput("releasePcSrc", pcSrc, taken);
      tick();
      expWb = word;
      checkOutput("releaseWb", memWbOut, expWb);
    end
  endtask

  initial begin
    logic [63:0] ex;
    logic [63:0] nop;

    // Reset with a load presented and an ack asserted: everything stays quiet.
    rst      = 1'b1;
    en       = 1'b1;
    flush    = 1'b0;
    memAck   = 1'b1;
    memRData = 24'h123456;
    exMemIn  = buildEx(4'd0, 24'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 24'h0);
    expWb    = '0;
    #12;
    checkOutput("rstReq", memReq, 0);
    checkOutput("rstStall", stall, 0);
    checkOutput("rstErr", memErr, 0);
    checkOutput("rstWb", memWbOut, 0);
    exMemIn = '0;
    memAck  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed scenarios.
    runAlu(4'd0, 24'h001234, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 24'h0, 1'b1, 1'b0);
    runMemOp(1'b0, 24'h10, 24'h0, 4'd7, 1'b1, 4'd0, 1'b0, 24'hABCDEF, 0, 0, 1'b0, 1'b0);
    runMemOp(1'b1, 24'h20, 24'h55, 4'd2, 1'b0, 4'd0, 1'b0, 24'hFFFFFF, 3, 0, 1'b0, 1'b0);
    runMemOp(1'b0, 24'h30, 24'h0, 4'd9, 1'b1, 4'd0, 1'b1, 24'h654321, 1, 1, 1'b1, 1'b0);
    runMemOp(1'b0, 24'h44, 24'h0, 4'd3, 1'b1, 4'd1, 1'b1, 24'h0F0F0F, 63, 0, 1'b0, 1'b1);
    checkOutput("lateAckNoErr", memErr, 0);
    runAlu(4'd2, 24'h000040, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 24'h0, 1'b1, 1'b0);
    runAlu(4'd2, 24'h000040, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 24'h0, 1'b1, 1'b0);
    runAlu(4'd4, 24'h000077, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 24'h1, 1'b0, 1'b0);
    runAlu(4'd7, 24'h000088, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 24'h2, 1'b1, 1'b1);

    // Access that never gets an ack.
    ex = buildEx(4'd0, 24'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 24'h0);
    applyStimulus(ex, 1'b1, 1'b0, 1'b0, 24'h0);
    tick();
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(ex, 1'b1, 1'b0, 1'b0, 24'($urandom));
      if (i == 1 || i == 64) begin
        checkOutput("toReq", memReq, 1);
        checkOutput("toErrBefore", memErr, 0);
      end
      tick();
    end
    nop = buildEx(4'd0, 24'h000ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 24'h0);
    applyStimulus(nop, 1'b1, 1'b0, 1'b0, 24'h0);
    checkOutput("toErr", memErr, 1);
    checkOutput("toReqDrop", memReq, 0);
    checkOutput("toIdle", stall, 0);
    checkOutput("toBubble", memWbOut, 0);
    tick();
    expWb = wbWord(1'b1, 1'b0, 4'd3, 24'h0, 24'h000ABC);
    checkOutput("toNextWb", memWbOut, expWb);
    runAlu(4'd0, 24'h000101, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 24'h0, 1'b1, 1'b0);
    checkOutput("toErrSticky", memErr, 1);
    rst = 1'b1;
    #1;
    checkOutput("toErrCleared", memErr, 0);
    #2;
    rst = 1'b0;
    expWb = '0;
    tick();

    // Randomized instruction stream.
    for (int t = 0; t < 40; t++) begin
      case ($urandom % 4)
        0, 3: runAlu(4'($urandom % 8), 24'($urandom), 1'($urandom % 2), 1'($urandom % 2),
                     1'($urandom % 2), 1'($urandom % 2), 4'($urandom), 24'($urandom),
                     1'($urandom % 4 != 0), 1'($urandom % 8 == 0));
        1: runMemOp(1'b0, 24'($urandom), 24'($urandom), 4'($urandom), 1'($urandom % 2),
                    4'($urandom % 8), 1'($urandom % 2), 24'($urandom), int'($urandom % 4),
                    int'($urandom % 3), 1'($urandom % 2), 1'($urandom % 2));
        default: runMemOp(1'b1, 24'($urandom), 24'($urandom), 4'($urandom), 1'($urandom % 2),
                          4'($urandom % 8), 1'($urandom % 2), 24'($urandom), int'($urandom % 4),
                          int'($urandom % 3), 1'($urandom % 2), 1'($urandom % 2));
      endcase
    end
    checkOutput("randNoErr", memErr, 0);

    // Asynchronous reset while a request is outstanding.
    runAlu(4'd0, 24'h00BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 24'h0, 1'b1, 1'b0);
    ex = buildEx(4'd0, 24'h60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 24'h0);
    applyStimulus(ex, 1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    applyStimulus(ex, 1'b0, 1'b0, 1'b1, 24'h777777);
    checkOutput("preRstReq", memReq, 1);
    checkOutput("preRstWb", memWbOut, expWb);
    rst = 1'b1;
    #1;
    checkOutput("asyncReq", memReq, 0);
    checkOutput("asyncStall", stall, 0);
    checkOutput("asyncWb", memWbOut, 0);
    nop = buildEx(4'd0, 24'h000321, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 24'h0);
    exMemIn = nop;
    en      = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("postRstReq", memReq, 0);
    checkOutput("postRstStall", stall, 0);
    tick();
    expWb = wbWord(1'b1, 1'b0, 4'd9, 24'h0, 24'h000321);
    checkOutput("postRstWb", memWbOut, expWb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
